// File: rtl/program_loader.sv
// program_loader: writes a framed byte stream (sync byte, 4-byte little-endian length, payload) into program memory from address 0.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing modulo-256 payload checksum byte.
module program_loader #(
  parameter int         XLEN_WIDTH = 32,
  parameter int         MEM_BYTES  = 1024,
  parameter logic [7:0] SYNC_BYTE  = 8'h55
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  write_enable,
  output logic [XLEN_WIDTH-1:0] write_address,
  output logic [7:0]            write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            o_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [31:0] LP_MEM_BYTES = 32'(MEM_BYTES);

  // rx_valid is a one-cycle strobe with no backpressure: a byte is consumed in
  // exactly the cycle rx_valid is high, and the loader can never stall it.

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_len;
  logic [1:0]  r_len_cnt;
  logic [31:0] r_cnt;
  logic [31:0] w_len_full;
  logic        w_sync;
  logic        w_restart;
  logic        w_write;

  assign w_sync     = rx_valid && (rx_data == SYNC_BYTE);
  assign w_restart  = w_sync && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_len_full = {rx_data, r_len[31:8]};
  // The counter never passes len, so the address stays below MEM_BYTES.
  assign w_write    = (r_state == S_DATA) && rx_valid && (r_cnt != r_len);
  assign o_state    = r_state;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       w_last;

  assign w_last = w_write && ((r_cnt + 32'd1) == r_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum <= 8'd0;
    end else if (w_restart) begin
      r_sum <= 8'd0;
    end else if (w_write) begin
      r_sum <= r_sum + rx_data;
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_sync) w_next = S_LEN;
      end
      S_LEN: begin
        if (rx_valid && (r_len_cnt == 2'd3)) begin
          if (w_len_full == 32'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            w_next = S_CHK;
`else
            w_next = S_DONE;
`endif
          end else if (w_len_full > LP_MEM_BYTES) begin
            w_next = S_ERR;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Leave on the last byte so a back-to-back checksum byte is not lost.
        if (w_last) w_next = S_CHK;
`else
        // Stay one extra cycle so busy covers the final write strobe.
        if (r_cnt == r_len) w_next = S_DONE;
`endif
      end
      S_CHK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (rx_valid) w_next = (rx_data == r_sum) ? S_DONE : S_ERR;
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_len         <= 32'd0;
      r_len_cnt     <= 2'd0;
      r_cnt         <= 32'd0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      r_state      <= w_next;
      busy         <= (w_next == S_LEN) || (w_next == S_DATA) || (w_next == S_CHK);
      done         <= (w_next == S_DONE);
      error        <= (w_next == S_ERR);
      write_enable <= w_write;
      if (w_write) begin
        write_address <= XLEN_WIDTH'(r_cnt);
        write_data    <= rx_data;
      end
      if (w_restart) begin
        r_len     <= 32'd0;
        r_len_cnt <= 2'd0;
        r_cnt     <= 32'd0;
      end else begin
        if ((r_state == S_LEN) && rx_valid) begin
          r_len     <= w_len_full;
          r_len_cnt <= r_len_cnt + 2'd1;
        end
        if (w_write) r_cnt <= r_cnt + 32'd1;
      end
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the program memory byte-write port: receives a framed byte stream (from the UART receiver) and writes it sequentially into instruction RAM, starting at byte address 0.
- Holds the core in reset (busy) while loading.
- Reports done or error status to the top level / LEDs.

Parameters:
- XLEN_WIDTH, 32, width of write_address (matches common package).
- MEM_BYTES, 1024, program memory size in bytes; upper bound on accepted length.
- SYNC_BYTE, 8'h55, frame start marker.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  single-cycle strobe: rx_data holds a received byte.
- rx_data  input  8  received byte.
- write_enable  output  1  one-cycle byte write strobe to program memory.
- write_address  output  XLEN_WIDTH  byte address of the current write.
- write_data  output  8  byte to write.
- busy  output  1  high while a frame is in progress; the top level ORs it into the core reset.
- done  output  1  sticky; last frame loaded successfully.
- error  output  1  sticky; last frame rejected.

Behaviour:
- Reset values:
  - state = IDLE.
  - write_enable = 0; write_address = 0; write_data = 0.
  - busy = 0; done = 0; error = 0.
  - Length, byte counter and checksum cleared.
- Reset asserted mid-frame aborts the frame immediately; no further writes occur.
- All outputs are registered. rx bytes are accepted only in a cycle where rx_valid = 1; there is no backpressure.
- States:
  - IDLE: rx_valid with rx_data == SYNC_BYTE -> LEN. Other bytes are ignored.
  - LEN: collect 4 bytes, little-endian, into len[31:0].
    - After the 4th byte: len == 0 -> DONE; len > MEM_BYTES -> ERR; otherwise -> DATA.
  - DATA: each rx_valid produces exactly one write in the NEXT cycle:
    - write_enable = 1 for one cycle.
    - write_data = that byte.
    - write_address = current counter (0, 1, 2, ...).
    - The counter increments after each write.
    - When the counter reaches len -> DONE, or -> CHK when checksum is enabled.
  - DONE: done = 1, error = 0.
  - ERR: error = 1, done = 0.
  - Restart from DONE/ERR: SYNC_BYTE -> LEN, clearing done, error and the counter. Other bytes are ignored.
- busy = 1 exactly in LEN, DATA and CHK; it rises the cycle after the sync byte and falls the cycle after the final write strobe.
- write_enable is never high outside DATA or on the cycle immediately after DATA exits. Back-to-back rx_valid on consecutive cycles must produce back-to-back writes with no byte lost.
- The address counter never exceeds MEM_BYTES-1. The oversize check guarantees this; no wrap-around is permitted.
- A sync byte received inside LEN or DATA is treated as ordinary data, not a restart.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload byte the FSM enters CHK and waits for one more byte.
  - That byte is compared with the 8-bit modulo-256 sum of all payload bytes.
  - Equal -> DONE; unequal -> ERR. Memory is already written either way; error only flags it.
  - Frames with len == 0 expect a checksum byte of 0x00.
- Undefined: no CHK state and no sum register; DATA goes straight to DONE after the last write.

Test Plan:
- Reset, then no input -> all outputs 0, state IDLE; bytes 0x12, 0xAB without a sync byte -> no write_enable, busy stays 0.
- Stream 55, 04 00 00 00, 13 00 00 00 -> four writes at addresses 0..3 with data 13, 00, 00, 00, each one cycle after its rx_valid. busy is high from the cycle after 55 until the cycle after the 4th write; then done = 1. (With checksum enabled, append 0x13.)
- Stream 55, 01 04 00 00 (len = 1025) -> ERR, error = 1, zero writes, busy low again.
- rx_valid high on 8 consecutive cycles in DATA -> 8 consecutive write_enable cycles at addresses 0..7, data matching input order.
- Reset asserted after 2 of 4 payload bytes -> outputs return to 0 asynchronously, no 3rd write; a fresh frame 55, 01 00 00 00, AA then writes AA at address 0.
- Checksum enabled: 55, 02 00 00 00, 01 02, 03 -> done = 1. Same frame with checksum 04 -> error = 1, with data still written at addresses 0 and 1.
